// File: rtl/phys_ready_table.sv
// Physical register ready table: one ready bit per physical register, combinational
// source-operand lookups and a busy counter. Optional macro CDB_BYPASS_EN forwards same-cycle writebacks to queries.
module phys_ready_table #(
    parameter  int PHYS_REGS   = 64,
    parameter  int QUERY_PORTS = 8,
    parameter  int CDB_PORTS   = 2,
    localparam int PHYS_WIDTH  = $clog2(PHYS_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [PHYS_WIDTH-1:0] alloc_paddr,
    input  logic [CDB_PORTS-1:0]  cdb_valid,
    input  logic [PHYS_WIDTH-1:0] cdb_paddr [CDB_PORTS],
    input  logic                  br_flush,
    input  logic [PHYS_WIDTH-1:0] rs1_in [QUERY_PORTS],
    input  logic [PHYS_WIDTH-1:0] rs2_in [QUERY_PORTS],
    output logic [QUERY_PORTS-1:0] rs1_valid,
    output logic [QUERY_PORTS-1:0] rs2_valid,
    output logic [PHYS_WIDTH:0]   busy_count
);

    // Lookup space rounded up to a power of two; tags past PHYS_REGS read ready.
    localparam int PAD_REGS = 1 << PHYS_WIDTH;

    logic [PHYS_REGS-1:0]   ready_r;
    logic [PHYS_REGS-1:0]   ready_next_s;
    logic [PHYS_REGS-1:0]   set_s;
    logic [PHYS_REGS-1:0]   clr_s;
    logic [PHYS_WIDTH:0]    busy_count_r;
    logic [PHYS_WIDTH:0]    busy_next_s;
    logic [PAD_REGS-1:0]    ready_pad_s;
    logic [PAD_REGS-1:0]    bypass_s;
    logic [QUERY_PORTS-1:0] rs1_valid_s;
    logic [QUERY_PORTS-1:0] rs2_valid_s;

    // Decode alloc and writeback requests into per-register clear/set masks (p0 excluded).
    always_comb begin
        set_s = '0;
        clr_s = '0;
        for (int j = 1; j < PHYS_REGS; j++) begin
            for (int c = 0; c < CDB_PORTS; c++) begin
                if (cdb_valid[c] && (cdb_paddr[c] == PHYS_WIDTH'(j))) begin
                    set_s[j] = 1'b1;
                end else begin
                    set_s[j] = set_s[j];
                end
            end
            if (alloc_valid && (alloc_paddr == PHYS_WIDTH'(j))) begin
                clr_s[j] = 1'b1;
            end else begin
                clr_s[j] = 1'b0;
            end
        end
    end

    // Next ready vector: flush beats everything, alloc beats writeback.
    always_comb begin
        if (br_flush) begin
            ready_next_s = '1;
        end else begin
            ready_next_s = (ready_r | set_s) & ~clr_s;
        end
        ready_next_s[0] = 1'b1;
    end

    // Busy count is recomputed from the next vector, so redundant ops never skew it.
    always_comb begin
        busy_next_s = '0;
        for (int j = 1; j < PHYS_REGS; j++) begin
            busy_next_s = busy_next_s + {{PHYS_WIDTH{1'b0}}, ~ready_next_s[j]};
        end
    end

    // Ready bits and busy counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r      <= '1;
            busy_count_r <= '0;
        end else begin
            ready_r      <= ready_next_s;
            busy_count_r <= busy_next_s;
        end
    end

    // Pad stored bits to the full tag space and build the writeback forwarding mask.
    always_comb begin
        ready_pad_s                = '1;
        ready_pad_s[PHYS_REGS-1:0] = ready_r;
        bypass_s                   = '0;
`ifdef CDB_BYPASS_EN
        for (int c = 0; c < CDB_PORTS; c++) begin
            if (cdb_valid[c]) begin
                bypass_s[cdb_paddr[c]] = 1'b1;
            end else begin
                bypass_s[cdb_paddr[c]] = bypass_s[cdb_paddr[c]];
            end
        end
`else
        bypass_s = '0;
`endif
    end

    // Source operand lookups; reset forces every query ready.
    always_comb begin
        rs1_valid_s = '0;
        rs2_valid_s = '0;
        for (int i = 0; i < QUERY_PORTS; i++) begin
            rs1_valid_s[i] = rst | ready_pad_s[rs1_in[i]] | bypass_s[rs1_in[i]];
            rs2_valid_s[i] = rst | ready_pad_s[rs2_in[i]] | bypass_s[rs2_in[i]];
        end
    end

    assign rs1_valid  = rs1_valid_s;
    assign rs2_valid  = rs2_valid_s;
    assign busy_count = busy_count_r;

endmodule

// File: tb/tb_phys_ready_table.sv
// Directed self-checking bench for phys_ready_table (default parameters).
module tb_phys_ready_table;

    logic       clk;
    logic       rst;
    logic       alloc_valid;
    logic [5:0] alloc_paddr;
    logic [1:0] cdb_valid;
    logic [5:0] cdb_paddr [2];
    logic       br_flush;
    logic [5:0] rs1_in [8];
    logic [5:0] rs2_in [8];
    logic [7:0] rs1_valid;
    logic [7:0] rs2_valid;
    logic [6:0] busy_count;

    int n_checks;
    int n_fail;

    phys_ready_table dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_paddr (alloc_paddr),
        .cdb_valid   (cdb_valid),
        .cdb_paddr   (cdb_paddr),
        .br_flush    (br_flush),
        .rs1_in      (rs1_in),
        .rs2_in      (rs2_in),
        .rs1_valid   (rs1_valid),
        .rs2_valid   (rs2_valid),
        .busy_count  (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid  = 1'b0;
        alloc_paddr  = 6'd0;
        cdb_valid    = 2'b00;
        cdb_paddr[0] = 6'd0;
        cdb_paddr[1] = 6'd0;
        br_flush     = 1'b0;
    endtask

    task automatic do_alloc(input logic [5:0] p);
        idle_inputs();
        alloc_valid = 1'b1;
        alloc_paddr = p;
        tick();
        idle_inputs();
        #1;
    endtask

    logic bypass_exp;

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef CDB_BYPASS_EN
        bypass_exp = 1'b1;
`else
        bypass_exp = 1'b0;
`endif
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            rs1_in[i] = 6'd0;
            rs2_in[i] = 6'd0;
        end
        rs1_in[0] = 6'd5;
        #2;
        check_val("in_reset_rs1", 32'(rs1_valid[0]), 32'd1);
        #10;
        rst = 1'b0;
        tick();

        // Reset state
        check_val("reset_rs1_p5", 32'(rs1_valid[0]), 32'd1);
        check_val("reset_rs2_p0", 32'(rs2_valid[0]), 32'd1);
        check_val("reset_busy", 32'(busy_count), 32'd0);

        // Alloc p5: invisible in the alloc cycle, cleared afterwards
        alloc_valid = 1'b1;
        alloc_paddr = 6'd5;
        #1;
        check_val("alloc_same_cycle", 32'(rs1_valid[0]), 32'd1);
        tick();
        idle_inputs();
        #1;
        check_val("alloc_next_cycle", 32'(rs1_valid[0]), 32'd0);
        check_val("alloc_busy", 32'(busy_count), 32'd1);

        // Writeback p5
        cdb_valid[0] = 1'b1;
        cdb_paddr[0] = 6'd5;
        #1;
        check_val("cdb_same_cycle", 32'(rs1_valid[0]), 32'(bypass_exp));
        tick();
        idle_inputs();
        #1;
        check_val("cdb_next_cycle", 32'(rs1_valid[0]), 32'd1);
        check_val("cdb_busy", 32'(busy_count), 32'd0);

        // Alloc p7 with both cdb ports writing p7: alloc wins
        rs1_in[1]    = 6'd7;
        alloc_valid  = 1'b1;
        alloc_paddr  = 6'd7;
        cdb_valid    = 2'b11;
        cdb_paddr[0] = 6'd7;
        cdb_paddr[1] = 6'd7;
        tick();
        idle_inputs();
        #1;
        check_val("alloc_wins_p7", 32'(rs1_valid[1]), 32'd0);
        check_val("alloc_wins_busy", 32'(busy_count), 32'd1);

        // Three allocs then flush together with alloc p10
        do_alloc(6'd3);
        do_alloc(6'd4);
        do_alloc(6'd9);
        rs1_in[2] = 6'd3;
        rs2_in[2] = 6'd9;
        rs1_in[3] = 6'd10;
        #1;
        check_val("pre_flush_busy", 32'(busy_count), 32'd4);
        check_val("pre_flush_p3", 32'(rs1_valid[2]), 32'd0);
        check_val("pre_flush_p9", 32'(rs2_valid[2]), 32'd0);
        br_flush    = 1'b1;
        alloc_valid = 1'b1;
        alloc_paddr = 6'd10;
        tick();
        idle_inputs();
        #1;
        check_val("flush_p3", 32'(rs1_valid[2]), 32'd1);
        check_val("flush_p9", 32'(rs2_valid[2]), 32'd1);
        check_val("flush_p10", 32'(rs1_valid[3]), 32'd1);
        check_val("flush_p7", 32'(rs1_valid[1]), 32'd1);
        check_val("flush_busy", 32'(busy_count), 32'd0);

        // Redundant operations leave the count alone
        do_alloc(6'd5);
        check_val("busy_after_p5", 32'(busy_count), 32'd1);
        do_alloc(6'd5);
        check_val("busy_realloc_p5", 32'(busy_count), 32'd1);
        cdb_valid[0] = 1'b1;
        cdb_paddr[0] = 6'd6;
        tick();
        idle_inputs();
        #1;
        check_val("busy_cdb_ready_reg", 32'(busy_count), 32'd1);
        cdb_valid    = 2'b11;
        cdb_paddr[0] = 6'd5;
        cdb_paddr[1] = 6'd5;
        tick();
        idle_inputs();
        #1;
        check_val("busy_dual_cdb", 32'(busy_count), 32'd0);
        check_val("dual_cdb_ready", 32'(rs1_valid[0]), 32'd1);

        // p0 is immune to alloc and writeback
        rs2_in[0] = 6'd0;
        do_alloc(6'd0);
        check_val("p0_alloc_ready", 32'(rs2_valid[0]), 32'd1);
        check_val("p0_alloc_busy", 32'(busy_count), 32'd0);
        alloc_valid  = 1'b1;
        alloc_paddr  = 6'd0;
        cdb_valid[0] = 1'b1;
        cdb_paddr[0] = 6'd0;
        tick();
        idle_inputs();
        #1;
        check_val("p0_both_ready", 32'(rs2_valid[0]), 32'd1);
        check_val("p0_both_busy", 32'(busy_count), 32'd0);

        // Asynchronous reset mid-sequence discards the pending alloc
        rs1_in[4] = 6'd20;
        rs1_in[5] = 6'd22;
        do_alloc(6'd20);
        do_alloc(6'd21);
        check_val("pre_rst_busy", 32'(busy_count), 32'd2);
        check_val("pre_rst_p20", 32'(rs1_valid[4]), 32'd0);
        alloc_valid = 1'b1;
        alloc_paddr = 6'd22;
        #1;
        rst = 1'b1;
        #1;
        check_val("async_rst_p20", 32'(rs1_valid[4]), 32'd1);
        check_val("async_rst_busy", 32'(busy_count), 32'd0);
        tick();
        idle_inputs();
        #1;
        rst = 1'b0;
        #1;
        check_val("rst_drop_p22", 32'(rs1_valid[5]), 32'd1);
        check_val("rst_drop_busy", 32'(busy_count), 32'd0);

        // Highest register seen through every query port
        do_alloc(6'd63);
        for (int i = 0; i < 8; i++) begin
            rs1_in[i] = 6'd63;
            rs2_in[i] = 6'd62;
        end
        #1;
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("p63_rs1_%0d", i), 32'(rs1_valid[i]), 32'd0);
            check_val($sformatf("p62_rs2_%0d", i), 32'(rs2_valid[i]), 32'd1);
        end
        check_val("p63_busy", 32'(busy_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phys_ready_table.md
PHYS_READY_TABLE -- requirements
Module: phys_ready_table

Interface
REQ-001 SHALL have parameter PHYS_REGS, default 64: number of physical registers tracked.
REQ-002 SHALL have parameter QUERY_PORTS, default 8: reservation-station entries queried per cycle.
REQ-003 SHALL have parameter CDB_PORTS, default 2: writeback broadcasts per cycle.
REQ-004 SHALL have localparam PHYS_WIDTH = $clog2(PHYS_REGS).
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 alloc_valid  in  1  dispatch is allocating a destination physical register this cycle.
REQ-008 alloc_paddr  in  PHYS_WIDTH  physical register being allocated.
REQ-009 cdb_valid[CDB_PORTS]  in  1 each  writeback broadcast valid.
REQ-010 cdb_paddr[CDB_PORTS]  in  PHYS_WIDTH each  physical register written back.
REQ-011 br_flush  in  1  pipeline flush on branch mispredict.
REQ-012 rs1_in[QUERY_PORTS], rs2_in[QUERY_PORTS]  in  PHYS_WIDTH each  source tags held by reservation-station entries.
REQ-013 rs1_valid[QUERY_PORTS], rs2_valid[QUERY_PORTS]  out  1 each  source operand ready.
REQ-014 busy_count  out  PHYS_WIDTH+1  number of registers currently not ready.

Function
REQ-015 SHALL hold one ready bit per physical register; 1 = value present in PRF.
REQ-016 Register p0 SHALL always read ready; alloc or cdb targeting p0 SHALL be ignored.
REQ-017 alloc_valid SHALL clear the ready bit of alloc_paddr at the next posedge.
REQ-018 Each valid cdb port SHALL set the ready bit of its cdb_paddr at the next posedge.
REQ-019 Same-cycle alloc and cdb to the same paddr: alloc wins; the bit ends cleared.
REQ-020 Two cdb ports naming the same paddr SHALL count as a single set.
REQ-021 rs1_valid[i]/rs2_valid[i] SHALL be combinational lookups of rs1_in[i]/rs2_in[i] against the stored bits, with zero-cycle latency.
REQ-022 Alloc SHALL NOT affect query outputs in the same cycle; the cleared bit is visible from the next cycle.
REQ-023 busy_count SHALL equal the number of cleared bits after every posedge: +1 per effective clear of a set bit, -1 per effective set of a cleared bit; no change for redundant operations.
REQ-024 busy_count SHALL NOT wrap; its maximum is PHYS_REGS-1 because p0 is excluded.
REQ-025 br_flush SHALL set every ready bit and zero busy_count at the next posedge, overriding alloc and cdb in that cycle.
REQ-026 Out-of-range query tags (>= PHYS_REGS, non-power-of-2 sizes) SHALL report ready.

Reset
REQ-027 rst SHALL immediately, without a clock, set all ready bits to 1 and busy_count to 0.
REQ-028 During reset, rs*_valid SHALL read 1 for every query.
REQ-029 rst asserted mid-operation SHALL discard all pending alloc and cdb inputs of that cycle.

Configuration
REQ-030 Macro CDB_BYPASS_EN SHALL control writeback forwarding to query outputs.
REQ-031 With CDB_BYPASS_EN defined, a query whose tag matches any valid same-cycle cdb_paddr SHALL report ready combinationally.
REQ-032 Without CDB_BYPASS_EN, a cdb write SHALL become visible to queries only in the cycle after the broadcast.
REQ-033 The macro SHALL NOT change stored state, busy_count, or reset behaviour.

Verification
REQ-034 Reset, then query rs1_in[0]=5 and rs2_in[0]=0 -> rs1_valid[0]=1, rs2_valid[0]=1, busy_count=0.
REQ-035 alloc p5 in cycle N -> rs1_valid for tag 5 is 1 in cycle N, 0 in cycle N+1; busy_count=1.
REQ-036 p5 busy, cdb_valid[0]=1 with paddr 5 in cycle M, query tag 5 -> 1 in cycle M with CDB_BYPASS_EN, else 0 in M and 1 in M+1; busy_count=0 after M.
REQ-037 Same cycle: alloc p7, cdb p7 on both ports -> p7 not ready, busy_count increments by exactly 1.
REQ-038 alloc p3, p4, p9 in three cycles, then br_flush together with alloc p10 -> all ready, busy_count=0.
REQ-039 alloc p0 and cdb p0 -> tag 0 always ready, busy_count unchanged; rst pulse mid-sequence between clock edges -> outputs ready immediately.
